// File: rtl/fetch_ctrl.sv
// Fetch controller: PC select, stall/flush steering, branch recovery,
// BTB update and branch performance counters.
module fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_imem_wait,
  input  logic        i_id_stall,
  input  logic        i_ex_br_valid,
  input  logic        i_ex_taken,
  input  logic [15:0] i_ex_target,
  input  logic [15:0] i_ex_pc,
  input  logic        i_ex_pred_taken,
  input  logic [15:0] i_ex_pred_target,
  input  logic        i_btb_hit,
  output logic [1:0]  o_pc_sel,
  output logic [15:0] o_redirect_pc,
  output logic        o_pc_en,
  output logic        o_ifid_en,
  output logic        o_ifid_flush,
  output logic        o_idex_flush,
  output logic        o_fetch_valid,
  output logic        o_btb_we,
  output logic [15:0] o_btb_wpc,
  output logic [15:0] o_btb_wtarget,
  output logic        o_btb_wvalid,
  output logic        o_mispredict,
  output logic [15:0] o_br_count,
  output logic [15:0] o_mispred_count
);

  localparam logic [1:0] SEL_SEQ   = 2'b00;
  localparam logic [1:0] SEL_BTB   = 2'b01;
  localparam logic [1:0] SEL_REDIR = 2'b10;
  localparam logic [1:0] SEL_HOLD  = 2'b11;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND,
    RECOVER
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] br_cnt_q, mp_cnt_q;

  logic        br_acc;
  logic        tgt_miss;
  logic        mp;
  logic [15:0] rec_pc;
  logic [1:0]  norm_sel;

  // Branches resolving outside RUN belong to a squashed path.
  assign br_acc   = (state_q == RUN) & i_ex_br_valid;
  assign tgt_miss = i_ex_target != i_ex_pred_target;
  assign mp       = br_acc &
                    ((i_ex_taken != i_ex_pred_taken) |
                     (i_ex_taken & i_ex_pred_taken & tgt_miss));
  assign rec_pc   = i_ex_taken ? i_ex_target : i_ex_pc + 16'd2;
  assign norm_sel = i_btb_hit ? SEL_BTB : SEL_SEQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pend_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    o_pc_sel      = SEL_HOLD;
    o_pc_en       = 1'b0;
    o_ifid_en     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_fetch_valid = 1'b0;
    o_mispredict  = 1'b0;
    o_redirect_pc = rec_pc;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (mp) begin
          o_mispredict = 1'b1;
          o_ifid_flush = 1'b1;
          o_idex_flush = 1'b1;
          if (i_imem_wait) begin
            pend_d  = rec_pc;
            state_d = PEND;
          end else begin
            o_pc_sel  = SEL_REDIR;
            o_pc_en   = 1'b1;
            o_ifid_en = 1'b1;
            state_d   = RECOVER;
          end
        end else if (i_imem_wait | i_id_stall) begin
          o_idex_flush = i_id_stall & ~i_imem_wait;
        end else begin
          o_pc_sel      = norm_sel;
          o_pc_en       = 1'b1;
          o_ifid_en     = 1'b1;
          o_fetch_valid = 1'b1;
        end
      end
      PEND: begin
        o_redirect_pc = pend_q;
        if (!i_imem_wait) begin
          o_pc_sel  = SEL_REDIR;
          o_pc_en   = 1'b1;
          o_ifid_en = 1'b1;
          state_d   = RECOVER;
        end
      end
      RECOVER: begin
        o_ifid_flush = 1'b1;
        state_d      = RUN;
        if (!i_imem_wait) begin
          o_pc_sel  = norm_sel;
          o_pc_en   = 1'b1;
          o_ifid_en = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Install on a missed or wrong taken target, invalidate on a false taken.
  assign o_btb_we      = br_acc &
                         ((i_ex_taken & (~i_ex_pred_taken | tgt_miss)) |
                          (~i_ex_taken & i_ex_pred_taken));
  assign o_btb_wvalid  = i_ex_taken;
  assign o_btb_wpc     = i_ex_pc;
  assign o_btb_wtarget = i_ex_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt_q <= 16'h0000;
      mp_cnt_q <= 16'h0000;
    end else begin
      if (br_acc && br_cnt_q != 16'hFFFF)
        br_cnt_q <= br_cnt_q + 16'd1;
      if (mp && mp_cnt_q != 16'hFFFF)
        mp_cnt_q <= mp_cnt_q + 16'd1;
    end
  end

  assign o_br_count      = br_cnt_q;
  assign o_mispred_count = mp_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: vector table for RUN-state behaviour
// plus hand sequences for pending redirect, reset and counter saturation.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_imem_wait, i_id_stall, i_ex_br_valid;
  logic        i_ex_taken, i_ex_pred_taken, i_btb_hit;
  logic [15:0] i_ex_target, i_ex_pc, i_ex_pred_target;
  logic [1:0]  o_pc_sel;
  logic [15:0] o_redirect_pc, o_btb_wpc, o_btb_wtarget;
  logic        o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush;
  logic        o_fetch_valid, o_btb_we, o_btb_wvalid, o_mispredict;
  logic [15:0] o_br_count, o_mispred_count;

  int n_chk = 0;
  int n_fail = 0;
  int exp_br = 0;
  int exp_mp = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .i_imem_wait(i_imem_wait), .i_id_stall(i_id_stall),
    .i_ex_br_valid(i_ex_br_valid), .i_ex_taken(i_ex_taken),
    .i_ex_target(i_ex_target), .i_ex_pc(i_ex_pc),
    .i_ex_pred_taken(i_ex_pred_taken),
    .i_ex_pred_target(i_ex_pred_target), .i_btb_hit(i_btb_hit),
    .o_pc_sel(o_pc_sel), .o_redirect_pc(o_redirect_pc),
    .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en),
    .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush),
    .o_fetch_valid(o_fetch_valid), .o_btb_we(o_btb_we),
    .o_btb_wpc(o_btb_wpc), .o_btb_wtarget(o_btb_wtarget),
    .o_btb_wvalid(o_btb_wvalid), .o_mispredict(o_mispredict),
    .o_br_count(o_br_count), .o_mispred_count(o_mispred_count)
  );

  typedef struct {
    logic        wt, st, bv, tk, pt;
    logic [15:0] tgt, pc, ptgt;
    logic        btb;
    logic [1:0]  e_sel;
    logic        e_pcen, e_ifen, e_iff, e_idf, e_fv;
    logic [15:0] e_rpc;
    logic        e_we, e_wv, e_mp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    i_imem_wait = 0; i_id_stall = 0; i_ex_br_valid = 0;
    i_ex_taken = 0; i_ex_pred_taken = 0; i_btb_hit = 0;
    i_ex_target = 0; i_ex_pc = 0; i_ex_pred_target = 0;
  endtask

  task automatic br(input logic tk, input logic pt, input logic [15:0] tgt,
                    input logic [15:0] pc, input logic [15:0] ptgt);
    i_ex_br_valid = 1; i_ex_taken = tk; i_ex_pred_taken = pt;
    i_ex_target = tgt; i_ex_pc = pc; i_ex_pred_target = ptgt;
  endtask

  task automatic chk_run_idle(input string nm);
    chk({nm, " pc_sel"}, o_pc_sel, 2'b00);
    chk({nm, " pc_en"}, o_pc_en, 1);
    chk({nm, " fetch_valid"}, o_fetch_valid, 1);
    chk({nm, " btb_we"}, o_btb_we, 0);
  endtask

  task automatic chk_recover(input string nm);
    chk({nm, " rec pc_sel"}, o_pc_sel, 2'b00);
    chk({nm, " rec fetch_valid"}, o_fetch_valid, 0);
    chk({nm, " rec ifid_flush"}, o_ifid_flush, 1);
    chk({nm, " rec idex_flush"}, o_idex_flush, 0);
  endtask

  initial begin
    //          wt st bv tk pt tgt      pc       ptgt    btb  sel   pe ie ff df fv rpc      we wv mp
    vecs[0]  = '{0, 0, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 2'b00, 1, 1, 0, 0, 1, 16'h0,    0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 16'h0,    16'h0,    16'h0,    1, 2'b01, 1, 1, 0, 0, 1, 16'h0,    0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 2'b11, 0, 0, 0, 0, 0, 16'h0,    0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 2'b11, 0, 0, 0, 1, 0, 16'h0,    0, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 0, 16'h0,    16'h0,    16'h0,    1, 2'b11, 0, 0, 0, 1, 0, 16'h0,    0, 0, 0};
    vecs[5]  = '{1, 1, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 2'b11, 0, 0, 0, 0, 0, 16'h0,    0, 0, 0};
    vecs[6]  = '{0, 0, 1, 1, 0, 16'h0040, 16'h0010, 16'h0000, 0, 2'b10, 1, 1, 1, 1, 0, 16'h0040, 1, 1, 1};
    vecs[7]  = '{0, 0, 1, 0, 1, 16'h0500, 16'hFFFE, 16'h0500, 0, 2'b10, 1, 1, 1, 1, 0, 16'h0000, 1, 0, 1};
    vecs[8]  = '{0, 0, 1, 1, 1, 16'h0200, 16'h0020, 16'h0300, 0, 2'b10, 1, 1, 1, 1, 0, 16'h0200, 1, 1, 1};
    vecs[9]  = '{0, 0, 1, 1, 1, 16'h0080, 16'h0030, 16'h0080, 0, 2'b00, 1, 1, 0, 0, 1, 16'h0,    0, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 0, 16'h0700, 16'h0040, 16'h0900, 0, 2'b00, 1, 1, 0, 0, 1, 16'h0,    0, 0, 0};
    vecs[11] = '{0, 1, 1, 1, 0, 16'h1234, 16'h0050, 16'h0000, 0, 2'b10, 1, 1, 1, 1, 0, 16'h1234, 1, 1, 1};
    vecs[12] = '{0, 0, 1, 0, 0, 16'h0000, 16'h0058, 16'h0000, 1, 2'b01, 1, 1, 0, 0, 1, 16'h0,    0, 0, 0};
    vecs[13] = '{1, 0, 1, 1, 1, 16'h0080, 16'h0060, 16'h0080, 0, 2'b11, 0, 0, 0, 0, 0, 16'h0,    0, 0, 0};

    idle();
    reset = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset pc_sel", o_pc_sel, 2'b11);
    chk("reset pc_en", o_pc_en, 0);
    chk("reset ifid_en", o_ifid_en, 0);
    chk("reset flushes", {o_ifid_flush, o_idex_flush}, 0);
    chk("reset btb_we", o_btb_we, 0);
    chk("reset mispredict", o_mispredict, 0);
    chk("reset counters", {o_br_count, o_mispred_count}, 0);

    @(negedge clk);
    reset = 0;
    #1;
    chk("boot pc_sel", o_pc_sel, 2'b11);
    chk("boot pc_en", o_pc_en, 0);
    chk("boot fetch_valid", o_fetch_valid, 0);
    @(negedge clk);
    #1;
    chk_run_idle("run1");
    @(negedge clk);
    #1;
    chk_run_idle("run2");

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      i_imem_wait = vecs[i].wt; i_id_stall = vecs[i].st;
      i_ex_br_valid = vecs[i].bv; i_ex_taken = vecs[i].tk;
      i_ex_pred_taken = vecs[i].pt; i_ex_target = vecs[i].tgt;
      i_ex_pc = vecs[i].pc; i_ex_pred_target = vecs[i].ptgt;
      i_btb_hit = vecs[i].btb;
      #1;
      chk($sformatf("v%0d pc_sel", i), o_pc_sel, vecs[i].e_sel);
      chk($sformatf("v%0d pc_en", i), o_pc_en, vecs[i].e_pcen);
      chk($sformatf("v%0d ifid_en", i), o_ifid_en, vecs[i].e_ifen);
      chk($sformatf("v%0d ifid_flush", i), o_ifid_flush, vecs[i].e_iff);
      chk($sformatf("v%0d idex_flush", i), o_idex_flush, vecs[i].e_idf);
      chk($sformatf("v%0d fetch_valid", i), o_fetch_valid, vecs[i].e_fv);
      chk($sformatf("v%0d btb_we", i), o_btb_we, vecs[i].e_we);
      chk($sformatf("v%0d mispredict", i), o_mispredict, vecs[i].e_mp);
      if (vecs[i].e_sel == 2'b10)
        chk($sformatf("v%0d redirect_pc", i), o_redirect_pc, vecs[i].e_rpc);
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d btb_wvalid", i), o_btb_wvalid, vecs[i].e_wv);
        chk($sformatf("v%0d btb_wpc", i), o_btb_wpc, vecs[i].pc);
      end
      if (vecs[i].bv) exp_br++;
      if (vecs[i].e_mp) exp_mp++;
      if (vecs[i].e_mp) begin
        @(negedge clk);
        idle();
        #1;
        chk_recover($sformatf("v%0d", i));
      end
    end
    @(negedge clk);
    idle();
    #1;
    chk("table br_count", o_br_count, exp_br);
    chk("table mispred_count", o_mispred_count, exp_mp);

    // Mispredict while memory busy: three held cycles then redirect.
    @(negedge clk);
    i_imem_wait = 1;
    br(1, 0, 16'h0100, 16'h0070, 16'h0000);
    #1;
    chk("pend0 pc_sel", o_pc_sel, 2'b11);
    chk("pend0 pc_en", o_pc_en, 0);
    chk("pend0 mispredict", o_mispredict, 1);
    chk("pend0 flushes", {o_ifid_flush, o_idex_flush}, 2'b11);
    chk("pend0 btb_we", o_btb_we, 1);
    exp_br++; exp_mp++;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      br(0, 1, 16'h0999, 16'h0999, 16'h0999);
      #1;
      chk($sformatf("pend%0d pc_sel", c), o_pc_sel, 2'b11);
      chk($sformatf("pend%0d pc_en", c), o_pc_en, 0);
      chk($sformatf("pend%0d squashed mp", c), o_mispredict, 0);
      chk($sformatf("pend%0d squashed we", c), o_btb_we, 0);
    end
    @(negedge clk);
    idle();
    #1;
    chk("pend pc_sel", o_pc_sel, 2'b10);
    chk("pend redirect_pc", o_redirect_pc, 16'h0100);
    chk("pend pc_en", o_pc_en, 1);
    @(negedge clk);
    #1;
    chk_recover("pend");
    @(negedge clk);
    #1;
    chk_run_idle("pend after");
    chk("pend br_count", o_br_count, exp_br);
    chk("pend mispred_count", o_mispred_count, exp_mp);

    // Reset while a redirect is pending discards it.
    @(negedge clk);
    i_imem_wait = 1;
    br(1, 0, 16'h0AAA, 16'h0080, 16'h0000);
    @(negedge clk);
    idle();
    i_imem_wait = 1;
    reset = 1;
    #1;
    chk("rstpend pc_sel", o_pc_sel, 2'b11);
    chk("rstpend counters", {o_br_count, o_mispred_count}, 0);
    @(negedge clk);
    reset = 0;
    i_imem_wait = 0;
    #1;
    chk("rstpend boot pc_en", o_pc_en, 0);
    @(negedge clk);
    #1;
    chk_run_idle("rstpend run");
    chk("rstpend ifid_flush", o_ifid_flush, 0);

    // Correctly predicted branches every cycle drive br_count to saturation.
    @(negedge clk);
    br(0, 0, 16'h0000, 16'h0100, 16'h0000);
    repeat (70000) @(negedge clk);
    idle();
    #1;
    chk("sat br_count", o_br_count, 16'hFFFF);
    chk("sat mispred_count", o_mispred_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
